// File: rtl/keypad_tx.sv
// Keypad front end: synchronizes and debounces seven raw buttons, queues presses
// in a pending register and emits them one at a time as valid/ready events plus strobes.
module keypad_tx #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int GAP_CYCLES      = 2
) (
  input  logic       clk_i,
  input  logic       arst_n_i,
  input  logic [6:0] btn_i,
  input  logic       key_ready_i,
  output logic       key_valid_o,
  output logic [2:0] key_code_o,
  output logic       KEY_0,
  output logic       KEY_1,
  output logic       KEY_2,
  output logic       KEY_3,
  output logic       KEY_OK,
  output logic       KEY_CLEAR,
  output logic       DOOR_SEALED,
  output logic       overflow_o
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  GAP_MAX = 8'(GAP_CYCLES - 1);

  logic [6:0]  sync1_q, sync2_q, stable_q, press_q;
  logic [15:0] cnt_q [7];
  logic [6:0]  pending_q, strobe_q, clear_mask;
  logic [2:0]  sel_code;
  logic [7:0]  gap_cnt_q;
  state_t      state_q;

  // Synchronizer and per-button debounce; press_q pulses for one cycle on a 0->1 of stable.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      press_q  <= '0;
      // NOTE: the counter array is reset element by element; it is flop state, not a RAM.
      for (int i = 0; i < 7; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      press_q <= '0;
      for (int i = 0; i < 7; i++) begin
        if (sync2_q[i] != stable_q[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            stable_q[i] <= ~stable_q[i];
            press_q[i]  <= ~stable_q[i];
            cnt_q[i]    <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 16'd1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sel_code   = '0;
    clear_mask = '0;
    for (int i = 6; i >= 0; i--) begin
      if (pending_q[i]) sel_code = 3'(i);
    end
    if (state_q == SEND && key_valid_o && key_ready_i) clear_mask = 7'(1) << key_code_o;
  end

  // Pending queue, sticky overflow and the IDLE/SEND/GAP emitter share one clocked block.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      pending_q   <= '0;
      overflow_o  <= 1'b0;
      state_q     <= IDLE;
      key_valid_o <= 1'b0;
      key_code_o  <= '0;
      strobe_q    <= '0;
      gap_cnt_q   <= '0;
    end else begin
      // A press on the bit being handed off this edge becomes a fresh event, not an overflow.
      pending_q  <= (pending_q & ~clear_mask) | press_q;
      overflow_o <= overflow_o | (|(press_q & pending_q & ~clear_mask));
      strobe_q   <= '0;
      case (state_q)
        IDLE: begin
          if (|pending_q) begin
            key_code_o  <= sel_code;
            key_valid_o <= 1'b1;
            state_q     <= SEND;
          end
        end
        SEND: begin
          if (key_ready_i) begin
            key_valid_o <= 1'b0;
            strobe_q    <= 7'(1) << key_code_o;
            gap_cnt_q   <= '0;
            state_q     <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_MAX) state_q <= IDLE;
          else gap_cnt_q <= gap_cnt_q + 8'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign KEY_0       = strobe_q[0];
  assign KEY_1       = strobe_q[1];
  assign KEY_2       = strobe_q[2];
  assign KEY_3       = strobe_q[3];
  assign KEY_OK      = strobe_q[4];
  assign KEY_CLEAR   = strobe_q[5];
  assign DOOR_SEALED = strobe_q[6];

endmodule
